apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
- APB requester (master) that drives the team's APB completer bus.
- Accepts single-transfer commands on a valid/ready command port and runs the APB SETUP→ACCESS sequence, honouring PREADY wait states.
- Generates the byte-XOR CRC in the top PWDATA byte on writes and checks it on read data.
- Returns one response per command (read data, PSLVERR, CRC error, timeout). It sits between a local controller or bus bridge and the APB completer.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be a multiple of 8 and at least 16.
- ADDR_WIDTH, 8, PADDR width.
- STRB_WIDTH, DATA_WIDTH/8, PSTRB width.
- TIMEOUT_CYCLES, 16, consecutive PREADY-low ACCESS cycles before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address, forwarded unmodified
- cmd_wdata  in  DATA_WIDTH  write data; top byte is ignored and replaced by CRC
- cmd_strb  in  STRB_WIDTH  write strobes
- cmd_prot  in  3  protection attribute
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_slverr  out  1  PSLVERR captured, or timeout
- rsp_crc_err  out  1  read CRC mismatch
- rsp_timeout  out  1  transfer aborted by timeout
- PADDR  out  ADDR_WIDTH
- PPROT  out  3
- PSEL  out  1
- PENABLE  out  1
- PWRITE  out  1
- PWDATA  out  DATA_WIDTH
- PSTRB  out  STRB_WIDTH
- PWAKEUP  out  1
- PREADY  in  1
- PRDATA  in  DATA_WIDTH
- PSLVERR  in  1

Behaviour:
- Reset: clock PCLK; reset PRESETn, asynchronous, active-low.
  - All outputs 0 during and after reset; state IDLE; wait counter 0.
  - Reset asserted mid-transfer drops PSEL/PENABLE immediately and produces no response.
- States: IDLE, SETUP, ACCESS (one-hot).
- cmd_ready = (state==IDLE) | (state==ACCESS & PENABLE & PREADY). This is a combinational path from PREADY.
- On acceptance, the following are registered from the command and held stable until the transfer ends:
  - PADDR, PPROT, PWRITE.
  - PWDATA = {crc, cmd_wdata[DATA_WIDTH-9:0]}.
  - PSTRB = cmd_write ? cmd_strb : 0.
- CRC: XOR of bytes 0..STRB_WIDTH-2 of the write data, with each byte whose PSTRB bit is 0 treated as 8'h00.
- IDLE → SETUP on acceptance. In SETUP: PSEL=1, PENABLE=0, exactly one cycle.
- SETUP → ACCESS unconditionally. In ACCESS: PSEL=1, PENABLE=1.
- ACCESS with PREADY=0:
  - Stay in ACCESS and increment the wait counter.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: go to IDLE, PSEL=PENABLE=0, and pulse rsp_valid with rsp_timeout=1, rsp_slverr=1, rsp_rdata=0, rsp_crc_err=0.
- ACCESS with PREADY=1 (completion): on the next edge, rsp_valid=1 for one cycle with:
  - rsp_slverr = PSLVERR.
  - rsp_rdata = PWRITE ? 0 : PRDATA.
  - rsp_crc_err = !PWRITE & !PSLVERR & (PRDATA top byte != XOR of PRDATA lower bytes).
  - rsp_timeout = 0.
  - Wait counter cleared.
- Completion-cycle next state:
  - SETUP if a new command is accepted in the same cycle (back-to-back, no IDLE gap; PENABLE=0 for that SETUP cycle).
  - Otherwise IDLE.
- No backpressure on responses. The consumer must always sample rsp_valid.
- At most one transfer is outstanding. cmd_valid while busy is held off by cmd_ready=0.
- PWAKEUP = registered (cmd_valid | state != IDLE). It rises one cycle after cmd_valid rises and falls one cycle after the return to IDLE with no pending command.
- Command outputs do not change while PSEL=1, except at a back-to-back reload.

Test Plan:
- Write: addr=0x10, wdata=0x00563412, strb=0xF, prot=0, PREADY high in first ACCESS.
  - Required: PWDATA=0x70563412; PSEL high for 2 cycles; rsp_valid with slverr=0.
- Partial write: wdata=0x00563412, strb=0b1011.
  - Required: PWDATA=0x26563412; PSTRB=0b1011.
- Read: addr=0x20, PREADY low for 3 ACCESS cycles, then PRDATA=0x70563412.
  - Required: PENABLE high 4 cycles; rsp_rdata=0x70563412; crc_err=0; PSTRB=0.
  - Repeat with PRDATA=0x71563412 → crc_err=1.
- Error: PSLVERR=1 at completion.
  - Required: rsp_slverr=1; rsp_crc_err=0.
- Timeout: PREADY held low.
  - Required: after 16 ACCESS cycles, PSEL drops; rsp_timeout=1, rsp_slverr=1.
  - Next command proceeds normally.
- Back-to-back and reset:
  - Two commands with cmd_valid held: second SETUP immediately follows the first completion, with no IDLE cycle.
  - PRESETn low during ACCESS: all outputs 0 asynchronously; no rsp_valid.

Source files
------------

// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// ApbRequester block: apb_requester
//
// Purpose:
//   APB requester (master). Takes single-transfer commands on a valid/ready
//   port and runs the SETUP -> ACCESS sequence on the APB bus, waiting through
//   PREADY-low wait states. The top byte of PWDATA carries a byte-XOR CRC of
//   the strobed lower bytes. Read data is checked against the same CRC scheme.
//   Exactly one response pulse is produced per accepted command.
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready is combinational
//                          from PREADY during the completion cycle)
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_strb,
//   cmd_prot               command payload
//   rsp_valid              one-cycle response pulse
//   rsp_rdata, rsp_slverr,
//   rsp_crc_err,
//   rsp_timeout            response payload, valid with rsp_valid
//   PADDR..PWAKEUP         APB requester outputs
//   PREADY, PRDATA,
//   PSLVERR                APB completer inputs
// ---------------------------------------------------------------------------
module apb_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_crc_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [2:0]            PPROT,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    output logic                  PWAKEUP,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 accept;
    logic                 complete;
    logic                 timeout_hit;
    logic [CNT_W-1:0]     wait_cnt;
    logic [STRB_WIDTH-1:0] eff_strb;
    logic [7:0]           wr_crc;
    logic                 rd_crc_bad;

    // XOR of every byte below the CRC byte; bytes whose mask bit is clear
    // contribute nothing, so a partial write only protects the bytes it sends.
    function automatic logic [7:0] byte_xor(input logic [DATA_WIDTH-1:0] d,
                                            input logic [STRB_WIDTH-1:0] m);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < STRB_WIDTH - 1; i++) begin
            if (m[i]) begin
                x = x ^ d[8*i +: 8];
            end
        end
        return x;
    endfunction

    // Reads carry no strobes, so their CRC byte degenerates to zero; the read
    // check covers every lower byte because the completer returns them all.
    always_comb begin
        eff_strb   = cmd_write ? cmd_strb : '0;
        wr_crc     = byte_xor(cmd_wdata, eff_strb);
        rd_crc_bad = (PRDATA[DATA_WIDTH-1 -: 8] != byte_xor(PRDATA, '1));
    end

    // Next-state and bus-phase decode. cmd_ready is also asserted in the
    // completion cycle so a waiting command reloads straight into SETUP.
    // It is held low while PRESETn is asserted so nothing is handshaken
    // during reset.
    always_comb begin
        state_next  = state;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        cmd_ready   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = PRESETn;
                if (cmd_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                PSEL       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    complete   = 1'b1;
                    cmd_ready  = PRESETn;
                    state_next = cmd_valid ? SETUP : IDLE;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        accept = cmd_valid & cmd_ready;
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts consecutive PREADY-low ACCESS cycles. It restarts at zero for
    // every transfer because it is cleared whenever the bus leaves ACCESS.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Command payload is captured only on acceptance, which keeps the APB
    // address/control/data stable for the whole transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PPROT  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= '0;
        end else if (accept) begin
            PADDR  <= cmd_addr;
            PPROT  <= cmd_prot;
            PWRITE <= cmd_write;
            PWDATA <= {wr_crc, cmd_wdata[DATA_WIDTH-9:0]};
            PSTRB  <= eff_strb;
        end
    end

    // Response pulse: one cycle after completion or timeout. Payload fields
    // are zero whenever rsp_valid is low.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_crc_err <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_crc_err <= 1'b0;
            rsp_timeout <= 1'b0;
            if (complete) begin
                rsp_valid   <= 1'b1;
                rsp_slverr  <= PSLVERR;
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_crc_err <= !PWRITE && !PSLVERR && rd_crc_bad;
            end else if (timeout_hit) begin
                rsp_valid   <= 1'b1;
                rsp_slverr  <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

    // Wake-up request follows pending work with one cycle of latency.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWAKEUP <= 1'b0;
        end else begin
            PWAKEUP <= cmd_valid | (state != IDLE);
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// ---------------------------------------------------------------------------
// Testbench for apb_requester (default parameters: 32-bit data, 8-bit
// address, timeout of 16 wait cycles). Expected responses are queued when a
// command is issued and compared when rsp_valid pulses.
// ---------------------------------------------------------------------------
module tb_apb_requester;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_crc_err;
    logic        rsp_timeout;
    logic [7:0]  PADDR;
    logic [2:0]  PPROT;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PWAKEUP;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic        crc_err;
        logic        timeout;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          selCycles;
    int          enCycles;
    logic [31:0] seenWdata;
    logic [3:0]  seenStrb;

    apb_requester dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_crc_err(rsp_crc_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWAKEUP(PWAKEUP),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    function automatic rsp_t mkRsp(input logic [31:0] rdata, input logic slverr,
                                   input logic crc_err, input logic timeout);
        rsp_t r;
        r.rdata   = rdata;
        r.slverr  = slverr;
        r.crc_err = crc_err;
        r.timeout = timeout;
        return r;
    endfunction

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResponse(input string tag);
        rsp_t e;
        checkOutput({tag, ".queued"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput({tag, ".rdata"},   rsp_rdata,          e.rdata);
            checkOutput({tag, ".slverr"},  32'(rsp_slverr),    32'(e.slverr));
            checkOutput({tag, ".crc_err"}, 32'(rsp_crc_err),   32'(e.crc_err));
            checkOutput({tag, ".timeout"}, 32'(rsp_timeout),   32'(e.timeout));
        end
    endtask

    // Issues one command from IDLE and plays the completer: PREADY stays low
    // for nwait ACCESS cycles, then goes high with rdata/slverr.
    task automatic applyStimulus(input string tag, input logic wr, input logic [7:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input int nwait, input logic [31:0] rdata,
                                 input logic slverr, input rsp_t expected);
        int   accessSeen;
        logic gotRsp;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        cmd_prot  = 3'b000;
        cmd_valid = 1'b1;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        exp_q.push_back(expected);
        selCycles  = 0;
        enCycles   = 0;
        accessSeen = 0;
        gotRsp     = 1'b0;
        seenWdata  = '0;
        seenStrb   = '0;
        for (int c = 0; c < 60 && !gotRsp; c++) begin
            tick;
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                gotRsp = 1'b1;
                checkResponse(tag);
            end else begin
                if (PSEL) selCycles++;
                if (PSEL && !PENABLE) begin
                    seenWdata = PWDATA;
                    seenStrb  = PSTRB;
                end
                if (PENABLE) begin
                    enCycles++;
                    PREADY  = (accessSeen >= nwait);
                    PRDATA  = rdata;
                    PSLVERR = slverr & PREADY;
                    accessSeen++;
                end else begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'b0;
                end
            end
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        checkOutput({tag, ".rsp_seen"}, 32'(gotRsp), 32'd1);
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;

        // Reset values
        #1;
        checkOutput("reset.psel",      32'(PSEL),      32'd0);
        checkOutput("reset.penable",   32'(PENABLE),   32'd0);
        checkOutput("reset.cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset.pwdata",    PWDATA,         32'd0);
        tick;
        tick;
        PRESETn = 1'b1;
        tick;
        checkOutput("idle.cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("idle.pwakeup",   32'(PWAKEUP),   32'd0);
        checkOutput("idle.psel",      32'(PSEL),      32'd0);

        // Full write: CRC 12^34^56 = 70
        applyStimulus("wr_full", 1'b1, 8'h10, 32'h00563412, 4'hF, 0, 32'h0, 1'b0,
                      mkRsp(32'h0, 1'b0, 1'b0, 1'b0));
        checkOutput("wr_full.pwdata", seenWdata,        32'h70563412);
        checkOutput("wr_full.pstrb",  32'(seenStrb),    32'hF);
        checkOutput("wr_full.psel_cycles", 32'(selCycles), 32'd2);
        checkOutput("wr_full.wakeup_hold", 32'(PWAKEUP), 32'd1);
        tick;
        checkOutput("wr_full.wakeup_fall", 32'(PWAKEUP), 32'd0);

        // Partial write: byte 2 masked, CRC 12^34 = 26
        applyStimulus("wr_part", 1'b1, 8'h14, 32'h00563412, 4'b1011, 0, 32'h0, 1'b0,
                      mkRsp(32'h0, 1'b0, 1'b0, 1'b0));
        checkOutput("wr_part.pwdata", seenWdata,     32'h26563412);
        checkOutput("wr_part.pstrb",  32'(seenStrb), 32'b1011);

        // Read with three wait states, good CRC
        applyStimulus("rd_good", 1'b0, 8'h20, 32'hFFFFFFFF, 4'hF, 3, 32'h70563412, 1'b0,
                      mkRsp(32'h70563412, 1'b0, 1'b0, 1'b0));
        checkOutput("rd_good.penable_cycles", 32'(enCycles), 32'd4);
        checkOutput("rd_good.pstrb", 32'(seenStrb), 32'd0);

        // Read with bad CRC
        applyStimulus("rd_bad", 1'b0, 8'h20, 32'h0, 4'hF, 3, 32'h71563412, 1'b0,
                      mkRsp(32'h71563412, 1'b0, 1'b1, 1'b0));

        // Slave error suppresses the CRC error
        applyStimulus("rd_slverr", 1'b0, 8'h24, 32'h0, 4'hF, 1, 32'h71563412, 1'b1,
                      mkRsp(32'h71563412, 1'b1, 1'b0, 1'b0));

        // Timeout after 16 PREADY-low ACCESS cycles
        applyStimulus("timeout", 1'b0, 8'h28, 32'h0, 4'hF, 1000, 32'h12345678, 1'b0,
                      mkRsp(32'h0, 1'b1, 1'b0, 1'b1));
        checkOutput("timeout.penable_cycles", 32'(enCycles), 32'd16);
        checkOutput("timeout.psel_after", 32'(PSEL), 32'd0);

        // Normal command after timeout
        applyStimulus("after_to", 1'b1, 8'h2C, 32'h00030201, 4'hF, 0, 32'h0, 1'b0,
                      mkRsp(32'h0, 1'b0, 1'b0, 1'b0));
        checkOutput("after_to.pwdata", seenWdata, 32'h00030201);

        // Back-to-back: write then read with cmd_valid held
        cmd_write = 1'b1;
        cmd_addr  = 8'h30;
        cmd_wdata = 32'h00030201;
        cmd_strb  = 4'hF;
        cmd_valid = 1'b1;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h0;
        exp_q.push_back(mkRsp(32'h0, 1'b0, 1'b0, 1'b0));
        tick;
        checkOutput("b2b.setupA_addr", 32'(PADDR), 32'h30);
        cmd_write = 1'b0;
        cmd_addr  = 8'h40;
        tick;
        #1;
        checkOutput("b2b.ready_at_completion", 32'(cmd_ready), 32'd1);
        exp_q.push_back(mkRsp(32'h77665544, 1'b0, 1'b0, 1'b0));
        tick;
        checkOutput("b2b.setupB_psel",    32'(PSEL),      32'd1);
        checkOutput("b2b.setupB_penable", 32'(PENABLE),   32'd0);
        checkOutput("b2b.setupB_addr",    32'(PADDR),     32'h40);
        checkOutput("b2b.setupB_pstrb",   32'(PSTRB),     32'd0);
        checkOutput("b2b.rspA_valid",     32'(rsp_valid), 32'd1);
        if (rsp_valid) checkResponse("b2b.rspA");
        cmd_valid = 1'b0;
        PRDATA    = 32'h77665544;
        tick;
        checkOutput("b2b.accessB_penable", 32'(PENABLE), 32'd1);
        tick;
        checkOutput("b2b.rspB_valid", 32'(rsp_valid), 32'd1);
        if (rsp_valid) checkResponse("b2b.rspB");
        checkOutput("b2b.idle_psel", 32'(PSEL), 32'd0);
        PREADY = 1'b0;
        tick;

        // Reset asserted during ACCESS
        cmd_write = 1'b0;
        cmd_addr  = 8'h50;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        checkOutput("rst_mid.in_access", 32'(PENABLE), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("rst_mid.psel",      32'(PSEL),      32'd0);
        checkOutput("rst_mid.penable",   32'(PENABLE),   32'd0);
        checkOutput("rst_mid.paddr",     32'(PADDR),     32'd0);
        checkOutput("rst_mid.pwakeup",   32'(PWAKEUP),   32'd0);
        checkOutput("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput("rst_mid.no_rsp", 32'(rsp_valid), 32'd0);
        end
        PREADY  = 1'b0;
        PRESETn = 1'b1;
        tick;
        checkOutput("rst_mid.post_rsp",  32'(rsp_valid), 32'd0);
        checkOutput("rst_mid.post_psel", 32'(PSEL),      32'd0);

        checkOutput("scoreboard.empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
